// File: rtl/tx_axis_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// tx_axis_arbiter_pkg
// Shared types and constants for the transmit-side AXI-Stream arbiter.
//   arb_state_t          : arbiter FSM encoding (IDLE, BUSY)
//   DEFAULT_DATA_WIDTH   : beat width feeding the 10G MAC
//   DEFAULT_DATA_NBYTES  : byte lanes per beat
//   DEFAULT_CNT_WIDTH    : width of the per-port frame counters
//   idx_width()          : port-index width, never below one bit
// ----------------------------------------------------------------------------
package tx_axis_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int DEFAULT_DATA_WIDTH  = 32;
   localparam int DEFAULT_DATA_NBYTES = DEFAULT_DATA_WIDTH / 8;
   localparam int DEFAULT_CNT_WIDTH   = 16;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_axis_arbiter_if.sv
// ----------------------------------------------------------------------------
// tx_axis_arbiter_if
// A bundle of LANES parallel AXI-Stream channels sharing one clock.
//   tdata  [LANES][DATA_WIDTH]   beat data
//   tkeep  [LANES][DATA_NBYTES]  byte enables
//   tvalid [LANES]               source has a beat
//   tlast  [LANES]               beat closes the frame
//   tready [LANES]               sink takes the beat
// Handshake: a beat transfers on a rising clk edge where tvalid and tready
// are both high on that lane. tdata/tkeep/tlast are meaningful only while
// tvalid is high. tready may depend combinationally on tvalid.
// modport master: drives the beat, receives tready.
// modport slave : receives the beat, drives tready.
// ----------------------------------------------------------------------------
interface tx_axis_arbiter_if
   import tx_axis_arbiter_pkg::*;
#(
   parameter int LANES      = 1,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   localparam int DATA_NBYTES = DATA_WIDTH / 8;

   logic [LANES-1:0][DATA_WIDTH-1:0]  tdata;
   logic [LANES-1:0][DATA_NBYTES-1:0] tkeep;
   logic [LANES-1:0]                  tvalid;
   logic [LANES-1:0]                  tlast;
   logic [LANES-1:0]                  tready;

   modport master (output tdata, output tkeep, output tvalid, output tlast,
                   input  tready);
   modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast,
                   output tready);
endinterface

// File: rtl/tx_axis_arbiter_rr_select.sv
// ----------------------------------------------------------------------------
// tx_axis_arbiter_rr_select
// Combinational round-robin picker: returns the first set bit of req,
// searching cyclically starting one position after last_grant.
//   req        in  N        request vector
//   last_grant in  IDX_W    most recently served index
//   idx        out IDX_W    chosen index (0 when any is low)
//   any        out 1        at least one request present
// ----------------------------------------------------------------------------
module tx_axis_arbiter_rr_select
   import tx_axis_arbiter_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int cand;

   // Walk offsets from farthest to nearest so the nearest requester after
   // last_grant overwrites every other candidate and wins.
   always_comb begin
      idx  = '0;
      any  = |req;
      cand = 0;
      for (int k = N; k >= 1; k--) begin
         cand = (int'(last_grant) + k) % N;
         if (req[cand]) idx = IDX_W'(cand);
      end
   end

endmodule

// File: rtl/tx_axis_arbiter.sv
// ----------------------------------------------------------------------------
// tx_axis_arbiter
// Frame-atomic round-robin arbiter placing N_PORTS user streams onto the
// single AXI-Stream input of the 10G transmit MAC. A grant lasts from the
// first beat up to and including the tlast handshake.
//   clk          in   MAC transmit clock
//   reset        in   synchronous, active-high
//   s_axis       slave  (N_PORTS lanes) user streams; only the granted
//                       lane's tready can be high
//   m_axis       master (1 lane) to MAC s00_axis
//   port_enable  in   N_PORTS   port may win arbitration when 1
//   grant_valid  out  1         a port owns the MAC
//   grant_idx    out  IDX_W     owning port
//   frame_count  out  N_PORTS x CNT_WIDTH  completed frames, wrapping
//   underrun     out  N_PORTS   pulse per cycle the owner stalls mid-frame
//   state        out  arb_state_t  current FSM state
// ----------------------------------------------------------------------------
module tx_axis_arbiter
   import tx_axis_arbiter_pkg::*;
#(
   parameter  int N_PORTS     = 2,
   parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter  int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
   localparam int DATA_NBYTES = DATA_WIDTH / 8,
   localparam int IDX_W       = idx_width(N_PORTS)
) (
   input  logic                              clk,
   input  logic                              reset,
   tx_axis_arbiter_if.slave                  s_axis,
   tx_axis_arbiter_if.master                 m_axis,
   input  logic [N_PORTS-1:0]                port_enable,
   output logic                              grant_valid,
   output logic [IDX_W-1:0]                  grant_idx,
   output logic [N_PORTS-1:0][CNT_WIDTH-1:0] frame_count,
   output logic [N_PORTS-1:0]                underrun,
   output arb_state_t                        state
);

   logic [IDX_W-1:0]       last_grant;
   logic [IDX_W-1:0]       sel_idx;
   logic                   sel_any;
   logic [N_PORTS-1:0]     req;
   logic                   beat_seen;
   logic                   busy;
   logic                   hs;
   logic                   frame_end;
   logic [N_PORTS-1:0]     tready_vec;

   logic [DATA_WIDTH-1:0]  mux_tdata;
   logic [DATA_NBYTES-1:0] mux_tkeep;
   logic                   mux_tvalid;
   logic                   mux_tlast;

   assign req  = s_axis.tvalid & port_enable;
   assign busy = (state == BUSY);

   tx_axis_arbiter_rr_select #(
      .N     (N_PORTS),
      .IDX_W (IDX_W)
   ) u_rr_select (
      .req        (req),
      .last_grant (last_grant),
      .idx        (sel_idx),
      .any        (sel_any)
   );

   // Zero-latency path from the owning port; everything reads as zero in IDLE
   // so nothing can slip through between frames.
   always_comb begin
      mux_tdata  = '0;
      mux_tkeep  = '0;
      mux_tvalid = 1'b0;
      mux_tlast  = 1'b0;
      if (busy) begin
         mux_tdata  = s_axis.tdata[grant_idx];
         mux_tkeep  = s_axis.tkeep[grant_idx];
         mux_tvalid = s_axis.tvalid[grant_idx];
         mux_tlast  = s_axis.tlast[grant_idx];
      end
   end

   assign m_axis.tdata[0]  = mux_tdata;
   assign m_axis.tkeep[0]  = mux_tkeep;
   assign m_axis.tvalid[0] = mux_tvalid;
   assign m_axis.tlast[0]  = mux_tlast;

   assign hs        = busy & mux_tvalid & m_axis.tready[0];
   assign frame_end = hs & mux_tlast;

   // Arbitration FSM. beat_seen separates "frame not started yet" from a
   // mid-frame stall, which is what underrun reports.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         last_grant  <= IDX_W'(N_PORTS - 1);
         beat_seen   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               beat_seen <= 1'b0;
               if (sel_any) begin
                  grant_idx   <= sel_idx;
                  grant_valid <= 1'b1;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (hs) beat_seen <= 1'b1;
               if (frame_end) begin
                  last_grant  <= grant_idx;
                  grant_valid <= 1'b0;
                  beat_seen   <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N_PORTS; i++) begin : g_port
      logic             owner;
      logic [CNT_WIDTH-1:0] cnt;

      assign owner         = busy && (grant_idx == IDX_W'(i));
      assign tready_vec[i] = owner & m_axis.tready[0];
      assign underrun[i]   = owner & beat_seen & ~mux_tvalid;
      assign frame_count[i] = cnt;

      always_ff @(posedge clk) begin
         if (reset) cnt <= '0;
         else if (frame_end && owner) cnt <= cnt + 1'b1;
      end
   end

   assign s_axis.tready = tready_vec;

endmodule
